// File: rtl/scalar_product_stream_loader_pkg.sv
// Shared types and default sizing for the scalar-product loader and its engine benches.
package scalar_product_stream_loader_pkg;

    localparam int unsigned NBITS_DEF   = 4;
    localparam int unsigned NDATA_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        WAIT,
        RESULT
    } state_t;

endpackage

// File: rtl/scalar_product_stream_loader.sv
// Streams element pairs into packed A/B vectors, kicks an external dot-product engine,
// and holds its result (or a timeout error) until the consumer takes it.
module scalar_product_stream_loader
    import scalar_product_stream_loader_pkg::*;
#(
    parameter int unsigned Nbits   = NBITS_DEF,
    parameter int unsigned Ndata   = NDATA_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Nbits-1:0]       in_a,
    input  logic [Nbits-1:0]       in_b,
    output logic [Ndata*Nbits-1:0] A,
    output logic [Ndata*Nbits-1:0] B,
    output logic                   eng_start,
    input  logic                   eng_done,
    input  logic [2*Nbits-1:0]     eng_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*Nbits-1:0]     res_data,
    output logic                   res_err
);

    localparam int unsigned CW = $clog2(Ndata) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] elem_cnt;
    logic [TW-1:0] wait_cnt;
    logic          xfer_c;
    logic          last_xfer_c;
    logic          timeout_c;

    assign xfer_c      = (state == FILL) && in_valid;
    assign last_xfer_c = xfer_c && (elem_cnt == CW'(Ndata - 1));
    assign timeout_c   = (wait_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (last_xfer_c) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (eng_done || timeout_c) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Handshake outputs registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b1;
            eng_start <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == FILL);
            eng_start <= (state_nxt == ISSUE);
            res_valid <= (state_nxt == RESULT);
        end
    end

    // Lane fill: the k-th accepted pair lands in lane k
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A        <= '0;
            B        <= '0;
            elem_cnt <= '0;
        end else if (xfer_c) begin
            for (int k = 0; k < int'(Ndata); k++) begin
                if (elem_cnt == CW'(k)) begin
                    A[k*Nbits +: Nbits] <= in_a;
                    B[k*Nbits +: Nbits] <= in_b;
                end
            end
            if (last_xfer_c) begin
                elem_cnt <= '0;
            end else begin
                elem_cnt <= elem_cnt + CW'(1);
            end
        end
    end

    // Wait-cycle counter and result capture; a done on the final wait cycle beats the timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
            if (eng_done) begin
                res_data <= eng_out;
                res_err  <= 1'b0;
            end else if (timeout_c) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_scalar_product_stream_loader.sv
// Self-checking bench: behavioural engine model, vector table and scoreboard queue.
module tb_scalar_product_stream_loader;
    import scalar_product_stream_loader_pkg::*;

    localparam int unsigned NB = NBITS_DEF;
    localparam int unsigned ND = NDATA_DEF;
    localparam int unsigned TO = TIMEOUT_DEF;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NB-1:0]    in_a = '0;
    logic [NB-1:0]    in_b = '0;
    logic [ND*NB-1:0] A;
    logic [ND*NB-1:0] B;
    logic             eng_start;
    logic             eng_done;
    logic [2*NB-1:0]  eng_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [2*NB-1:0]  res_data;
    logic             res_err;

    logic             eng_auto = 1'b1;
    int               eng_lat = 1;
    logic             mdl_done = 1'b0;
    logic [2*NB-1:0]  mdl_out = '0;
    logic             man_done = 1'b0;
    logic [2*NB-1:0]  man_out = '0;

    int total = 0;
    int bad = 0;
    int starts = 0;

    typedef struct {
        logic [15:0] a_vec;
        logic [15:0] b_vec;
        int          lat;
        bit          tog;
        logic [7:0]  exp_data;
    } vec_t;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        logic [15:0] a_vec;
        logic [15:0] b_vec;
    } exp_t;

    exp_t sb[$];
    vec_t tab[5];

    assign eng_done = eng_auto ? mdl_done : man_done;
    assign eng_out  = eng_auto ? mdl_out  : man_out;

    scalar_product_stream_loader #(.Nbits(NB), .Ndata(ND), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .A(A), .B(B), .eng_start(eng_start), .eng_done(eng_done), .eng_out(eng_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (eng_start) starts++;

    // Engine model: dot product of A and B, done pulse eng_lat cycles after eng_start is seen
    initial begin
        logic [7:0] acc;
        forever begin
            @(posedge clk); #1;
            if (eng_start && eng_auto) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc + 8'(A[k*4 +: 4]) * 8'(B[k*4 +: 4]);
                repeat (eng_lat) @(posedge clk);
                #1; mdl_done = 1'b1; mdl_out = acc;
                @(posedge clk); #1; mdl_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got bound expired want event", name);
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input bit tog);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            in_valid = 1'b1;
            in_a = av[k*4 +: 4];
            in_b = bv[k*4 +: 4];
            while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
            if (!in_ready) fail("in_ready_wait");
            @(posedge clk); #1;
            if (tog) begin
                in_valid = 1'b0; in_a = 4'h9; in_b = 4'h9;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic [15:0] av, input logic [15:0] bv);
        exp_t x;
        x.data = d; x.err = e; x.a_vec = av; x.b_vec = bv;
        sb.push_back(x);
    endtask

    task automatic get_result(input int hold);
        int n = 0;
        exp_t e;
        logic [7:0] held;
        while (!res_valid && n < 300) begin @(posedge clk); #1; n++; end
        if (!res_valid) fail("res_valid_wait");
        if (sb.size() == 0) begin
            fail("scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_err", 32'(res_err), 32'(e.err));
        check("vec_A", 32'(A), 32'(e.a_vec));
        check("vec_B", 32'(B), 32'(e.b_vec));
        held = res_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 4'h7; in_b = 4'h7;
            @(posedge clk); #1;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        check("hs_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("after_hs_valid", 32'(res_valid), 32'd0);
        check("after_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int s0;
        tab[0] = '{16'h2321, 16'h1456, 1,  1'b0, 8'd30};
        tab[1] = '{16'hAA11, 16'hAA55, 3,  1'b1, 8'd210};
        tab[2] = '{16'hFFFF, 16'hFFFF, 5,  1'b0, 8'd132};
        tab[3] = '{16'h4370, 16'h2307, 2,  1'b1, 8'd17};
        tab[4] = '{16'h1111, 16'h2222, 64, 1'b0, 8'd8};

        #23;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            eng_auto = 1'b1;
            eng_lat = tab[i].lat;
            s0 = starts;
            push(tab[i].exp_data, 1'b0, tab[i].a_vec, tab[i].b_vec);
            send(tab[i].a_vec, tab[i].b_vec, tab[i].tog);
            get_result(0);
            check("start_pulses", 32'(starts - s0), 32'd1);
        end

        // Consumer stall in RESULT
        eng_lat = 2;
        push(8'd30, 1'b0, 16'h2321, 16'h1456);
        send(16'h2321, 16'h1456, 1'b0);
        get_result(10);

        // Engine never answers: exactly TIMEOUT wait cycles then error
        eng_auto = 1'b0; man_done = 1'b0;
        push(8'd0, 1'b1, 16'h3121, 16'h5454);
        send(16'h3121, 16'h5454, 1'b0);
        check("to_issue", 32'(eng_start), 32'd1);
        repeat (TO) @(posedge clk);
        #1;
        check("to_not_yet", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("to_fired", 32'(res_valid), 32'd1);
        get_result(0);

        // Stray eng_done during FILL and ISSUE is ignored
        man_out = 8'hEE; man_done = 1'b1;
        push(8'd17, 1'b0, 16'h4370, 16'h2307);
        send(16'h4370, 16'h2307, 1'b0);
        check("stray_issue", 32'(eng_start), 32'd1);
        @(posedge clk); #1;
        man_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stray_no_result", 32'(res_valid), 32'd0);
        man_out = 8'd17; man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        get_result(0);

        // Reset mid-FILL discards partial lanes
        eng_auto = 1'b1; eng_lat = 1;
        in_valid = 1'b1; in_a = 4'h5; in_b = 4'h5;
        repeat (2) @(posedge clk);
        #2; reset = 1'b0;
        #1;
        check("midfill_rst_A", 32'(A), 32'd0);
        check("midfill_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        push(8'd30, 1'b0, 16'h2321, 16'h1456);
        send(16'h2321, 16'h1456, 1'b0);
        get_result(0);

        // Reset mid-WAIT abandons the transaction
        eng_auto = 1'b0; man_done = 1'b0;
        send(16'h9999, 16'h9999, 1'b0);
        repeat (3) @(posedge clk);
        #3; reset = 1'b0;
        #1;
        check("midwait_rst_B", 32'(B), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        eng_auto = 1'b1; eng_lat = 2;
        push(8'd210, 1'b0, 16'hAA11, 16'hAA55);
        send(16'hAA11, 16'hAA55, 1'b1);
        get_result(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scalar_product_stream_loader.md
SCALAR_PRODUCT_STREAM_LOADER -- requirements
Module: scalar_product_stream_loader

Interface
REQ-001 SHALL have parameter Nbits, default 4, element width in bits.
REQ-002 SHALL have parameter Ndata, default 4, elements per vector.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before error.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: element pair offered.
REQ-007 SHALL have port in_ready, output, 1: loader accepts pair.
REQ-008 SHALL have port in_a, input, Nbits: element of A.
REQ-009 SHALL have port in_b, input, Nbits: element of B.
REQ-010 SHALL have port A, output, Ndata*Nbits: packed vector to engine.
REQ-011 SHALL have port B, output, Ndata*Nbits: packed vector to engine.
REQ-012 SHALL have port eng_start, output, 1: one-cycle compute request.
REQ-013 SHALL have port eng_done, input, 1: engine result valid.
REQ-014 SHALL have port eng_out, input, 2*Nbits: engine scalar product.
REQ-015 SHALL have port res_valid, output, 1: result held for consumer.
REQ-016 SHALL have port res_ready, input, 1: consumer accepts result.
REQ-017 SHALL have port res_data, output, 2*Nbits: captured result.
REQ-018 SHALL have port res_err, output, 1: result is a timeout, qualified by res_valid.

Function
REQ-019 SHALL implement states FILL, ISSUE, WAIT, RESULT; reset state FILL.
REQ-020 SHALL drive in_ready=1 only in FILL; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-021 SHALL write the k-th accepted pair (k=0..Ndata-1) into lane k, bits [k*Nbits +: Nbits], of A and B; lane 0 is the first pair.
REQ-022 SHALL use an element counter of width clog2(Ndata)+1; on the Ndata-th transfer it clears to 0 and the state moves to ISSUE.
REQ-023 SHALL hold A and B stable from leaving FILL until the next FILL write.
REQ-024 SHALL assert eng_start for exactly the one ISSUE cycle, then enter WAIT.
REQ-025 SHALL sample eng_done only in WAIT; eng_done in any other state is ignored.
REQ-026 In WAIT, eng_done=1 SHALL capture eng_out into res_data unmodified, with no width change or saturation, clear res_err, and move to RESULT.
REQ-027 In WAIT, a cycle counter SHALL count from 0; if it reaches TIMEOUT-1 with eng_done=0, the block SHALL set res_data=0 and res_err=1 and move to RESULT.
REQ-028 eng_done on the same cycle the counter reaches TIMEOUT-1 SHALL take priority over timeout.
REQ-029 In RESULT, res_valid SHALL be 1 with res_data/res_err stable until res_valid && res_ready, then return to FILL next cycle.
REQ-030 SHALL keep in_ready=0 during the RESULT handshake cycle; a new fill starts only from the next cycle.
REQ-031 Latency from last input transfer to res_valid SHALL be 2 + (WAIT cycles until eng_done) cycles; minimum 3.

Reset
REQ-032 reset=0 SHALL immediately, independent of clk, force: state FILL; counters 0; A, B, res_data 0; eng_start, res_valid, res_err 0.
REQ-033 in_ready SHALL read 1 after reset release; in_ready is a function of state.
REQ-034 Reset mid-FILL, mid-WAIT or mid-RESULT SHALL discard partial data; the next result needs Ndata fresh transfers.

Structure
REQ-035 A shared package SHALL hold the state enum (FILL, ISSUE, WAIT, RESULT) and the default Nbits/Ndata/TIMEOUT constants, shared with scalar_product_Nmac benches.
REQ-036 The block SHALL be single-module; the engine (scalar_product_Nmac) stays external, and benches connect it directly to A/B/eng_out.

Verification
REQ-037 Stream (1,6),(2,5),(3,4),(2,1) with in_valid held high -> A=16'h2321, B=16'h1456; one eng_start pulse; res_data=30, res_err=0.
REQ-038 Stream (1,5),(1,5),(10,10),(10,10) with in_valid toggling every cycle -> 4 transfers only; res_data=210.
REQ-039 Hold res_ready=0 for 10 cycles in RESULT -> res_valid and res_data stable; in_ready=0; in_valid ignored.
REQ-040 Hold eng_done=0 in WAIT -> after TIMEOUT=64 WAIT cycles, res_valid=1, res_err=1, res_data=0.
REQ-041 Assert reset=0 after 2 transfers, then stream 4 new pairs -> only the new pairs appear in A/B; one correct result.
REQ-042 Pulse eng_done during FILL/ISSUE -> no state change; result taken only from the WAIT-phase eng_done.
